// File: rtl/instr_seq_ctrl_pkg.sv
// rtl/instr_seq_ctrl_pkg.sv - shared opcode, IR field, flag and state definitions for the sequencer
package instr_seq_ctrl_pkg;

    // Instruction register field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int TGT_LSB = 0;

    // Delay counter width; covers the full 1..15 hold range
    localparam int CNT_W = 4;

    // Control-flow opcodes; everything with opc[4]=0 is a datapath op
    localparam logic [OPC_W-1:0] OPC_JMP = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_JZ  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_JNZ = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_HLT = 5'b10011;

    // Datapath flag bit positions within {sign, zero, overflow, carry}
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_SIGN  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_DELAY = 3'd3,
        ST_NEXT  = 3'd4,
        ST_HALT  = 3'd5
    } seq_state_t;

    // Opcodes 0..15 are committed by the datapath; 16 and up are sequencer-only or NOP
    function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
        return ~opc[OPC_W-1];
    endfunction

endpackage

// File: rtl/instr_delay_cnt.sv
// rtl/instr_delay_cnt.sv - execute-hold counter, counts 0..DELAY-1 and flags the last cycle
module instr_delay_cnt
    import instr_seq_ctrl_pkg::*;
#(
    parameter int DELAY = 4
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

    logic [CNT_W-1:0] cnt;

    assign done = (cnt == LAST);

    // Clear on load and after the final hold cycle so the counter idles at zero
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt <= '0;
        end else if (load || (count && done)) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// rtl/instr_seq_ctrl.sv - fetch/execute/delay/next instruction sequencer with branch and halt
module instr_seq_ctrl
    import instr_seq_ctrl_pkg::*;
#(
    parameter int PC_W  = 4,
    parameter int DELAY = 4
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic [31:0]     ir,
    output logic            exec_en,
    input  logic [3:0]      flags,
    output logic            busy,
    output logic            halted
);

    seq_state_t state, state_nxt;

    logic [PC_W-1:0]  pc;
    logic [31:0]      ir_q;
    logic [OPC_W-1:0] opc;
    logic [PC_W-1:0]  target;
    logic             taken;

    logic ir_load;
    logic pc_clear;
    logic pc_step;
    logic pc_jump;
    logic cnt_load;
    logic cnt_count;
    logic cnt_done;

    // Only the zero flag steers branches; the rest belong to the datapath
    logic flags_unused;
    assign flags_unused = ^{flags[FLAG_SIGN], flags[FLAG_OVF], flags[FLAG_CARRY]};

    assign opc       = ir_q[OPC_MSB:OPC_LSB];
    assign target    = ir_q[TGT_LSB +: PC_W];
    assign imem_addr = pc;
    assign ir        = ir_q;
    assign busy      = (state == ST_FETCH) || (state == ST_EXEC) ||
                       (state == ST_DELAY) || (state == ST_NEXT);
    assign halted    = (state == ST_HALT);

    instr_delay_cnt #(
        .DELAY (DELAY)
    ) u_delay_cnt (
        .clk     (clk),
        .sys_rst (sys_rst),
        .load    (cnt_load),
        .count   (cnt_count),
        .done    (cnt_done)
    );

    // Branch decision from the held instruction and the live zero flag
    always_comb begin
        taken = 1'b0;
        case (opc)
            OPC_JMP: taken = 1'b1;
            OPC_JZ:  taken = flags[FLAG_ZERO];
            OPC_JNZ: taken = ~flags[FLAG_ZERO];
            default: taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        state_nxt = state;
        exec_en   = 1'b0;
        ir_load   = 1'b0;
        pc_clear  = 1'b0;
        pc_step   = 1'b0;
        pc_jump   = 1'b0;
        cnt_load  = 1'b0;
        cnt_count = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_clear  = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_load   = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                exec_en  = is_alu_op(opc);
                cnt_load = 1'b1;
                if (opc == OPC_HLT) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                cnt_count = 1'b1;
                if (cnt_done) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (taken) begin
                    pc_jump = 1'b1;
                end else begin
                    pc_step = 1'b1;
                end
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    pc_clear  = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Program counter: restart at zero, jump to target, or step with natural wrap
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pc <= '0;
        end else if (pc_clear) begin
            pc <= '0;
        end else if (pc_jump) begin
            pc <= target;
        end else if (pc_step) begin
            pc <= pc + PC_W'(1);
        end
    end

    // Instruction register captures the memory word during FETCH only
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ir_q <= '0;
        end else if (ir_load) begin
            ir_q <= imem_data;
        end
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb/tb_instr_seq_ctrl.sv - directed self-checking bench for instr_seq_ctrl
module tb_instr_seq_ctrl;

    localparam int PC_W  = 4;
    localparam int DELAY = 4;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_JMP = 5'b10000;
    localparam logic [4:0] OP_JZ  = 5'b10001;
    localparam logic [4:0] OP_JNZ = 5'b10010;
    localparam logic [4:0] OP_HLT = 5'b10011;
    localparam logic [4:0] OP_NOP = 5'b10100;

    logic            clk;
    logic            sys_rst;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic [31:0]     ir;
    logic            exec_en;
    logic [3:0]      flags;
    logic            busy;
    logic            halted;

    logic [31:0] mem [16];

    int checks;
    int errors;
    int cyc;
    int exec_cnt;
    int consec_cnt;
    logic prev_exec;
    int exec_cyc [$];

    assign imem_data = mem[imem_addr];

    instr_seq_ctrl #(
        .PC_W  (PC_W),
        .DELAY (DELAY)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .ir        (ir),
        .exec_en   (exec_en),
        .flags     (flags),
        .busy      (busy),
        .halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] tgt);
        return {opc, 23'h05A5A5, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exec_en) begin
                exec_cnt++;
                exec_cyc.push_back(cyc);
                if (prev_exec) consec_cnt++;
            end
            prev_exec = exec_en;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        exec_cnt   = 0;
        consec_cnt = 0;
        prev_exec  = 1'b0;
        sys_rst    = 1'b0;
        start      = 1'b0;
        flags      = 4'b0000;
        for (int i = 0; i < 16; i++) mem[i] = mk(OP_NOP, 4'd0);
        mem[0] = mk(OP_ADD, 4'd1);
        mem[1] = mk(OP_ADD, 4'd2);
        mem[2] = mk(OP_ADD, 4'd3);
        mem[3] = mk(OP_JMP, 4'd9);
        mem[9] = mk(OP_HLT, 4'd0);

        step(2);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_exec", 32'(exec_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // Release and start on the first edge
        sys_rst = 1'b1;
        start   = 1'b1;
        step(1);
        check("fetch0_addr", 32'(imem_addr), 32'd0);
        check("fetch0_busy", 32'(busy), 32'd1);
        check("fetch0_exec", 32'(exec_en), 32'd0);
        step(1);
        start = 1'b0;
        check("exec0_pulse", 32'(exec_en), 32'd1);
        check("exec0_ir", ir, mk(OP_ADD, 4'd1));
        step(6);
        check("fetch1_addr", 32'(imem_addr), 32'd1);
        step(1);
        check("exec1_pulse", 32'(exec_en), 32'd1);
        step(6);
        check("fetch2_addr", 32'(imem_addr), 32'd2);
        step(7);
        check("fetch3_addr", 32'(imem_addr), 32'd3);
        step(1);
        check("jmp_no_exec", 32'(exec_en), 32'd0);
        start = 1'b1;
        step(3);
        start = 1'b0;
        step(3);
        check("jmp_target", 32'(imem_addr), 32'd9);
        check("period", 32'(exec_cyc[1] - exec_cyc[0]), 32'(DELAY + 3));
        step(1);
        check("hlt_no_exec", 32'(exec_en), 32'd0);
        step(1);
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_busy", 32'(busy), 32'd0);
        step(3);
        check("hlt_pc_hold", 32'(imem_addr), 32'd9);
        check("hlt_ir_hold", ir, mk(OP_HLT, 4'd0));
        check("exec_cnt_a", 32'(exec_cnt), 32'd3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("restart_addr", 32'(imem_addr), 32'd0);
        check("restart_halted", 32'(halted), 32'd0);

        // Reset in the middle of the hold phase of word 1
        step(7);
        check("pre_rst_addr", 32'(imem_addr), 32'd1);
        step(3);
        sys_rst = 1'b0;
        #1;
        check("midrst_addr", 32'(imem_addr), 32'd0);
        check("midrst_ir", ir, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_exec", 32'(exec_en), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        step(3);
        sys_rst = 1'b1;
        step(10);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("exec_cnt_b", 32'(exec_cnt), 32'd5);

        // Conditional branches
        mem[0]  = mk(OP_JMP, 4'd4);
        mem[4]  = mk(OP_JZ, 4'd12);
        mem[5]  = mk(OP_JNZ, 4'd7);
        mem[7]  = mk(OP_HLT, 4'd0);
        mem[12] = mk(OP_HLT, 4'd0);
        flags = 4'b0100;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        check("jz_fetch4", 32'(imem_addr), 32'd4);
        step(7);
        check("jz_taken", 32'(imem_addr), 32'd12);
        step(2);
        check("jz_halted", 32'(halted), 32'd1);
        flags = 4'b0000;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        check("jz2_fetch4", 32'(imem_addr), 32'd4);
        step(1);
        flags = 4'b0100;
        step(4);
        flags = 4'b0000;
        step(2);
        check("jz_not_taken", 32'(imem_addr), 32'd5);
        step(7);
        check("jnz_taken", 32'(imem_addr), 32'd7);
        step(2);
        check("jnz_halted", 32'(halted), 32'd1);

        // PC wrap from 15 and NOP handling
        mem[0]  = mk(OP_JMP, 4'd15);
        mem[15] = mk(OP_SUB, 4'd6);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        check("fetch15_addr", 32'(imem_addr), 32'd15);
        mem[0] = mk(OP_NOP, 4'd15);
        step(1);
        check("exec15_pulse", 32'(exec_en), 32'd1);
        step(6);
        check("wrap_addr", 32'(imem_addr), 32'd0);
        step(1);
        check("nop_no_exec", 32'(exec_en), 32'd0);
        check("nop_ir", ir, mk(OP_NOP, 4'd15));
        step(6);
        check("nop_next_addr", 32'(imem_addr), 32'd1);

        check("exec_cnt_final", 32'(exec_cnt), 32'd6);
        check("exec_consec", 32'(consec_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
